dmem_access_ctrl: RTL and testbench

Sequences every data-memory access issued by the instruction held in the EX/MEM pipeline register. It drives a req/ready data-memory bus, formats store lanes and load results, and raises a global `stall` that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes. It sits between the EX/MEM and MEM/WB registers and reports misaligned-access and bus-error events to the exception logic.

---
 rtl/dmem_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: drives the req/ready bus, formats
// store lanes and load results, and stalls the upstream pipeline until done.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_memRead,
  input  logic        MEM_memWrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_aluOut,
  input  logic [31:0] MEM_data2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        exc_misalign,
  output logic        exc_bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] loadData_q, loadData_d;
  logic        loadValid_q, loadValid_d;
  logic        excBus_q, excBus_d;
  logic        isLoad_q, isLoad_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  byteOff_q, byteOff_d;

  logic        accessPresent;
  logic        misaligned;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  function automatic logic [31:0] formatLoad(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  return {24'b0, shifted[7:0]};
      3'b101:  return {16'b0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  assign accessPresent = MEM_memRead | MEM_memWrite;

  always_comb begin
    misaligned = 1'b0;
    case (MEM_funct3[1:0])
      2'b01:   misaligned = MEM_aluOut[0];
      2'b10:   misaligned = (MEM_aluOut[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    storeBe    = 4'b1111;
    storeWdata = MEM_data2;
    case (MEM_funct3)
      3'b000: begin
        storeBe    = 4'b0001 << MEM_aluOut[1:0];
        storeWdata = {4{MEM_data2[7:0]}};
      end
      3'b001: begin
        storeBe    = MEM_aluOut[1] ? 4'b1100 : 4'b0011;
        storeWdata = {2{MEM_data2[15:0]}};
      end
      default: begin
        storeBe    = 4'b1111;
        storeWdata = MEM_data2;
      end
    endcase
  end

  // Bus outputs are only loaded in IDLE so they stay frozen through WAIT.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    loadData_d   = loadData_q;
    loadValid_d  = 1'b0;
    excBus_d     = 1'b0;
    isLoad_d     = isLoad_q;
    funct3_d     = funct3_q;
    byteOff_d    = byteOff_q;
    stall        = 1'b0;
    exc_misalign = 1'b0;

    case (state_q)
      IDLE: begin
        if (accessPresent) begin
          if (misaligned) begin
            exc_misalign = 1'b1;
          end else begin
            stall     = 1'b1;
            req_d     = 1'b1;
            we_d      = MEM_memWrite;
            addr_d    = {MEM_aluOut[31:2], 2'b00};
            be_d      = MEM_memWrite ? storeBe : 4'b1111;
            wdata_d   = MEM_memWrite ? storeWdata : 32'h0;
            cnt_d     = 8'h00;
            isLoad_d  = ~MEM_memWrite;
            funct3_d  = MEM_funct3;
            byteOff_d = MEM_aluOut[1:0];
            state_d   = WAIT;
          end
        end
      end

      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (dmem_ready) begin
          req_d    = 1'b0;
          excBus_d = dmem_err;
          if (isLoad_q && !dmem_err) begin
            loadData_d  = formatLoad(funct3_q, byteOff_q, dmem_rdata);
            loadValid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == LastCount) begin
          req_d    = 1'b0;
          excBus_d = 1'b1;
          state_d  = DONE;
        end
      end

      // EX/MEM still holds the finished instruction here, so never restart.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= 8'h00;
      loadData_q  <= 32'h0;
      loadValid_q <= 1'b0;
      excBus_q    <= 1'b0;
      isLoad_q    <= 1'b0;
      funct3_q    <= 3'b000;
      byteOff_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      loadData_q  <= loadData_d;
      loadValid_q <= loadValid_d;
      excBus_q    <= excBus_d;
      isLoad_q    <= isLoad_d;
      funct3_q    <= funct3_d;
      byteOff_q   <= byteOff_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = loadData_q;
  assign load_valid = loadValid_q;
  assign exc_bus    = excBus_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a short timeout so the abort path
// is reachable in a handful of cycles.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MEM_memRead;
  logic        MEM_memWrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_aluOut;
  logic [31:0] MEM_data2;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        exc_misalign;
  logic        exc_bus;

  int total = 0;
  int bad   = 0;

  int          stallCnt, reqCnt, ebCnt, lvCnt;
  logic        busWe;
  logic [31:0] busAddr, busWdata;
  logic [3:0]  busBe;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MEM_memRead  (MEM_memRead),
    .MEM_memWrite (MEM_memWrite),
    .MEM_funct3   (MEM_funct3),
    .MEM_aluOut   (MEM_aluOut),
    .MEM_data2    (MEM_data2),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .dmem_err     (dmem_err),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .exc_misalign (exc_misalign),
    .exc_bus      (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] d2);
    MEM_memRead  = rd;
    MEM_memWrite = wr;
    MEM_funct3   = f3;
    MEM_aluOut   = addr;
    MEM_data2    = d2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access from IDLE, answering after readyDelay idle WAIT cycles,
  // and returns in the DONE cycle with stall/req counts and the bus snapshot.
  task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] d2,
                           input logic [31:0] rdata, input logic err, input int readyDelay);
    stallCnt = 0;
    reqCnt   = 0;
    applyStimulus(rd, wr, f3, addr, d2);
    #1;
    if (stall) stallCnt++;
    if (dmem_req) reqCnt++;
    tick();
    busWe    = dmem_we;
    busAddr  = dmem_addr;
    busBe    = dmem_be;
    busWdata = dmem_wdata;
    for (int i = 0; i < readyDelay; i++) begin
      if (stall) stallCnt++;
      if (dmem_req) reqCnt++;
      dmem_err = 1'b1;
      tick();
    end
    if (stall) stallCnt++;
    if (dmem_req) reqCnt++;
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    dmem_err   = err;
    tick();
    dmem_ready = 1'b0;
    dmem_err   = 1'b0;
    if (stall) stallCnt++;
    if (dmem_req) reqCnt++;
  endtask

  task automatic leaveDone();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    dmem_err   = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #3;
    checkOutput("rst_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst_we", {31'b0, dmem_we}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_lv", {31'b0, load_valid}, 32'd0);
    checkOutput("rst_eb", {31'b0, exc_bus}, 32'd0);
    checkOutput("rst_mis", {31'b0, exc_misalign}, 32'd0);
    checkOutput("rst_be", {28'b0, dmem_be}, 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_ld", load_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW 0x100, ready on the first WAIT cycle
    runAccess(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    checkOutput("lw_stall_cycles", stallCnt, 32'd2);
    checkOutput("lw_req_cycles", reqCnt, 32'd1);
    checkOutput("lw_addr", busAddr, 32'h100);
    checkOutput("lw_be", {28'b0, busBe}, 32'hF);
    checkOutput("lw_we", {31'b0, busWe}, 32'd0);
    checkOutput("lw_lv", {31'b0, load_valid}, 32'd1);
    checkOutput("lw_data", load_data, 32'hDEADBEEF);
    checkOutput("lw_eb", {31'b0, exc_bus}, 32'd0);
    leaveDone();
    checkOutput("lw_lv_after", {31'b0, load_valid}, 32'd0);

    // LB 0x103, then LBU presented back-to-back from the DONE cycle
    runAccess(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1'b0, 0);
    checkOutput("lb_data", load_data, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    #1;
    checkOutput("b2b_done_stall", {31'b0, stall}, 32'd0);
    tick();
    checkOutput("b2b_done_noreq", {31'b0, dmem_req}, 32'd0);
    runAccess(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1'b0, 0);
    checkOutput("lbu_stall_cycles", stallCnt, 32'd2);
    checkOutput("lbu_data", load_data, 32'h00000080);
    leaveDone();

    // LH upper half and LHU lower half
    runAccess(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1'b0, 0);
    checkOutput("lh_data", load_data, 32'hFFFF8011);
    leaveDone();
    runAccess(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80112233, 1'b0, 0);
    checkOutput("lhu_data", load_data, 32'h00002233);
    leaveDone();

    // LW with two idle WAIT cycles; err held high there must be ignored
    runAccess(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b0, 2);
    checkOutput("lwwait_stall_cycles", stallCnt, 32'd4);
    checkOutput("lwwait_req_cycles", reqCnt, 32'd3);
    checkOutput("lwwait_data", load_data, 32'h12345678);
    checkOutput("lwwait_eb", {31'b0, exc_bus}, 32'd0);
    leaveDone();

    // SH 0x202
    runAccess(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 0);
    checkOutput("sh_we", {31'b0, busWe}, 32'd1);
    checkOutput("sh_addr", busAddr, 32'h200);
    checkOutput("sh_be", {28'b0, busBe}, 32'hC);
    checkOutput("sh_wdata", busWdata, 32'hABCDABCD);
    checkOutput("sh_lv", {31'b0, load_valid}, 32'd0);
    leaveDone();

    // SB 0x301 and SW 0x400
    runAccess(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000005A, 32'h0, 1'b0, 0);
    checkOutput("sb_be", {28'b0, busBe}, 32'h2);
    checkOutput("sb_wdata", busWdata, 32'h5A5A5A5A);
    checkOutput("sb_addr", busAddr, 32'h300);
    leaveDone();
    runAccess(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    checkOutput("sw_be", {28'b0, busBe}, 32'hF);
    checkOutput("sw_wdata", busWdata, 32'hCAFEF00D);
    leaveDone();

    // Read and write both set behaves as a store
    runAccess(1'b1, 1'b1, 3'b010, 32'h600, 32'h11223344, 32'h55555555, 1'b0, 0);
    checkOutput("both_we", {31'b0, busWe}, 32'd1);
    checkOutput("both_lv", {31'b0, load_valid}, 32'd0);
    leaveDone();

    // Bus error on a load
    runAccess(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h99999999, 1'b1, 0);
    checkOutput("err_eb", {31'b0, exc_bus}, 32'd1);
    checkOutput("err_lv", {31'b0, load_valid}, 32'd0);
    leaveDone();
    checkOutput("err_eb_after", {31'b0, exc_bus}, 32'd0);

    // Misaligned LW 0x101 stays in IDLE
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    checkOutput("mis_exc", {31'b0, exc_misalign}, 32'd1);
    checkOutput("mis_stall", {31'b0, stall}, 32'd0);
    reqCnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dmem_req) reqCnt++;
    end
    checkOutput("mis_req_cycles", reqCnt, 32'd0);
    checkOutput("mis_exc_held", {31'b0, exc_misalign}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("mis_exc_clear", {31'b0, exc_misalign}, 32'd0);
    tick();

    // Timeout with TIMEOUT=4 and ready held low
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    #1;
    stallCnt = 0; reqCnt = 0; ebCnt = 0; lvCnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall) stallCnt++;
      if (dmem_req) reqCnt++;
      if (exc_bus) ebCnt++;
      if (load_valid) lvCnt++;
      if (i < 5) tick();
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (stall) stallCnt++;
      if (dmem_req) reqCnt++;
      if (exc_bus) ebCnt++;
      if (load_valid) lvCnt++;
    end
    checkOutput("to_stall_cycles", stallCnt, 32'd5);
    checkOutput("to_req_cycles", reqCnt, 32'd4);
    checkOutput("to_eb_pulses", ebCnt, 32'd1);
    checkOutput("to_lv_pulses", lvCnt, 32'd0);
    checkOutput("to_req_dropped", {31'b0, dmem_req}, 32'd0);

    // Reset asserted during the second WAIT cycle
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h800, 32'h0);
    tick();
    tick();
    checkOutput("mrst_req_before", {31'b0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_req_drop", {31'b0, dmem_req}, 32'd0);
    checkOutput("mrst_stall_idle", {31'b0, stall}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("mrst_stall_clear", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    dmem_err   = 1'b1;
    ebCnt = 0; lvCnt = 0; reqCnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exc_bus) ebCnt++;
      if (load_valid) lvCnt++;
      if (dmem_req) reqCnt++;
    end
    dmem_ready = 1'b0;
    dmem_err   = 1'b0;
    checkOutput("mrst_eb_pulses", ebCnt, 32'd0);
    checkOutput("mrst_lv_pulses", lvCnt, 32'd0);
    checkOutput("mrst_req_cycles", reqCnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
